serial_add_sequencer: RTL

SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

---
 rtl/serial_add_sequencer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial adder front end. It feeds one bit pair
// per cycle to an external shared 1-bit full adder, LSB first, and collects
// the returned sum bits into a shift register.
// Optional build macro: SERIAL_ADD_CHECK_EN adds an adder self-check that
// drives the sticky adder_err flag.
module serial_add_sequencer #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                add_a,
    output logic                add_b,
    output logic                add_cin,
    input  logic                add_sum,
    input  logic                add_cout,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow,
    output logic                adder_err
);

    // One spare counter bit, so the count never wraps inside a run.
    localparam int CW = $clog2(NUM_BITS) + 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t              state, state_nxt;
    logic [NUM_BITS-1:0] a_reg, b_reg, sum_reg;
    logic                carry_reg;
    logic                ovf_reg;
    logic [CW-1:0]       cnt;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: start is only looked at in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == LAST) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, serial shifting, carry and result collection
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= carry_in;
                        sum_reg   <= '0;
                        ovf_reg   <= 1'b0;
                        cnt       <= '0;
                    end
                end
                ST_RUN: begin
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    // First processed bit ends up at bit 0 after NUM_BITS shifts
                    sum_reg   <= {add_sum, sum_reg[NUM_BITS-1:1]};
                    carry_reg <= add_cout;
                    cnt       <= cnt + 1'b1;
                    // Latch the final carry separately so it survives the
                    // next operand capture into carry_reg.
                    if (cnt == LAST) ovf_reg <= add_cout;
                end
                default: ;
            endcase
        end
    end

    // Adder operands are only presented while running
    always_comb begin
        add_a   = 1'b0;
        add_b   = 1'b0;
        add_cin = 1'b0;
        if (state == ST_RUN) begin
            add_a   = a_reg[0];
            add_b   = b_reg[0];
            add_cin = carry_reg;
        end
    end

    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign sum      = sum_reg;
    assign overflow = ovf_reg;

`ifdef SERIAL_ADD_CHECK_EN
    logic err_reg;
    logic exp_sum, exp_cout;

    assign exp_sum  = add_a ^ add_b ^ add_cin;
    assign exp_cout = (add_a & add_b) | (add_a & add_cin) | (add_b & add_cin);

    // Sticky fault flag: any disagreement with a reference full adder in RUN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_reg <= 1'b0;
        end else if (state == ST_RUN &&
                     (add_sum != exp_sum || add_cout != exp_cout)) begin
            err_reg <= 1'b1;
        end
    end

    assign adder_err = err_reg;
`else
    assign adder_err = 1'b0;
`endif

endmodule
